// File: rtl/dmi_req_ctrl_pkg.sv
// Shared definitions for the DMI request controller.
//   - Status encodings reported on rd_status and held in the sticky register.
//   - FSM state enum used by the controller.
package dmi_req_ctrl_pkg;

    localparam logic [1:0] DMI_OK   = 2'b00;
    localparam logic [1:0] DMI_FAIL = 2'b10;
    localparam logic [1:0] DMI_BUSY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } dmi_state_e;

endpackage

// File: rtl/dmi_req_ctrl_if.sv
// DMI channel between the JTAG-side request controller and the debug module.
//   master : the controller (drives the request, consumes the response)
//   slave  : the debug module (accepts the request, returns the response)
// Signals:
//   dmi_req_valid/ready/addr/data/write : request channel
//   dmi_rsp_valid/data/err              : one-cycle response
//   dmi_hard_reset                      : one-cycle abort / sticky clear pulse
interface dmi_req_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              dmi_req_valid;
    logic              dmi_req_ready;
    logic [ADDR_W-1:0] dmi_req_addr;
    logic [31:0]       dmi_req_data;
    logic              dmi_req_write;
    logic              dmi_rsp_valid;
    logic [31:0]       dmi_rsp_data;
    logic              dmi_rsp_err;
    logic              dmi_hard_reset;

    modport master (
        output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_write,
        input  dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_err,
        input  dmi_hard_reset
    );

    modport slave (
        input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_write,
        output dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_err,
        output dmi_hard_reset
    );
endinterface

// File: rtl/dmi_timeout_cnt.sv
// Cycle counter bounding the time spent waiting in REQ or RSP.
//   clk, rst_n : clock and asynchronous active-low reset
//   i_clr      : synchronous clear (priority over i_en)
//   i_en       : increment this cycle
//   o_expire   : count has reached TIMEOUT_CYCLES-1
module dmi_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == LAST);
endmodule

// File: rtl/dmi_req_ctrl.sv
// JTAG DTM side DMI request controller.
// Turns a DR-update strobe into a single valid/ready request to the debug
// module, waits for the one-cycle response, and reports status back to the DR.
//   jtag_tck, jtag_trst_n : clock and asynchronous active-low reset
//   wr_addr, wr_data      : DR address / write data (low ADDR_W address bits used)
//   wr_intf, wr_enab      : request strobe and write(1)/read(0) qualifier
//   rd_data               : last successful read data
//   rd_status             : 00 ok, 10 failed, 11 busy
//   dmi                   : DMI channel (master side)
module dmi_req_ctrl
    import dmi_req_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        jtag_tck,
    input  logic        jtag_trst_n,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        wr_intf,
    input  logic        wr_enab,
    output logic [31:0] rd_data,
    output logic [1:0]  rd_status,
    dmi_req_ctrl_if.master dmi
);
    dmi_state_e        r_state;
    logic [1:0]        r_sticky;
    logic [31:0]       r_rd_data;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic [31:0]       r_req_data;
    logic              r_req_write;

    logic w_expire;
    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_err_event;
    logic w_busy_event;
    logic w_unused_addr;

    assign w_unused_addr = ^wr_addr[31:ADDR_W];

    // Counter is held at zero in IDLE, so entry into REQ starts at 0; the
    // REQ->RSP handshake clears it again for the response wait.
    assign w_cnt_clr = dmi.dmi_hard_reset || (r_state == ST_IDLE) ||
                       (r_state == ST_REQ && dmi.dmi_req_ready);
    assign w_cnt_en  = (r_state != ST_IDLE);

    dmi_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (jtag_tck),
        .rst_n    (jtag_trst_n),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .o_expire (w_expire)
    );

    // Handshake / response take precedence over timeout expiry.
    assign w_err_event  = (r_state == ST_REQ && !dmi.dmi_req_ready && w_expire) ||
                          (r_state == ST_RSP && dmi.dmi_rsp_valid && dmi.dmi_rsp_err) ||
                          (r_state == ST_RSP && !dmi.dmi_rsp_valid && w_expire);
    assign w_busy_event = wr_intf && (r_state != ST_IDLE);

    always_ff @(posedge jtag_tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) begin
            r_state     <= ST_IDLE;
            r_sticky    <= DMI_OK;
            r_rd_data   <= '0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_req_write <= 1'b0;
        end else if (dmi.dmi_hard_reset) begin
            r_state     <= ST_IDLE;
            r_sticky    <= DMI_OK;
            r_req_valid <= 1'b0;
        end else begin
            // First error wins: sticky only changes while it reads OK.
            if (r_sticky == DMI_OK) begin
                if (w_err_event) begin
                    r_sticky <= DMI_FAIL;
                end else if (w_busy_event) begin
                    r_sticky <= DMI_BUSY;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (wr_intf && r_sticky == DMI_OK) begin
                        r_req_addr  <= wr_addr[ADDR_W-1:0];
                        r_req_data  <= wr_data;
                        r_req_write <= wr_enab;
                        r_req_valid <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmi.dmi_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_RSP;
                    end else if (w_expire) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_RSP: begin
                    if (dmi.dmi_rsp_valid) begin
                        if (!dmi.dmi_rsp_err && !r_req_write) begin
                            r_rd_data <= dmi.dmi_rsp_data;
                        end
                        r_state <= ST_IDLE;
                    end else if (w_expire) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_status = (r_sticky != DMI_OK)   ? r_sticky :
                       (r_state  != ST_IDLE)  ? DMI_BUSY : DMI_OK;

    assign dmi.dmi_req_valid = r_req_valid;
    assign dmi.dmi_req_addr  = r_req_addr;
    assign dmi.dmi_req_data  = r_req_data;
    assign dmi.dmi_req_write = r_req_write;
endmodule

// File: tb/tb_dmi_req_ctrl.sv
// Directed testbench for dmi_req_ctrl (TIMEOUT_CYCLES=8).
module tb_dmi_req_ctrl;
    logic        clk;
    logic        rst_n;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_intf;
    logic        wr_enab;
    logic [31:0] rd_data;
    logic [1:0]  rd_status;

    int n_total;
    int n_pass;

    dmi_req_ctrl_if #(.ADDR_W(7)) dmi ();

    dmi_req_ctrl #(
        .ADDR_W         (7),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .jtag_tck    (clk),
        .jtag_trst_n (rst_n),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_intf     (wr_intf),
        .wr_enab     (wr_enab),
        .rd_data     (rd_data),
        .rd_status   (rd_status),
        .dmi         (dmi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic wr);
        wr_addr = addr;
        wr_data = data;
        wr_enab = wr;
        wr_intf = 1'b1;
        step();
        wr_intf = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        dmi.dmi_rsp_valid = 1'b1;
        dmi.dmi_rsp_data  = data;
        dmi.dmi_rsp_err   = err;
        step();
        dmi.dmi_rsp_valid = 1'b0;
        dmi.dmi_rsp_err   = 1'b0;
    endtask

    task automatic hard_reset();
        dmi.dmi_hard_reset = 1'b1;
        step();
        dmi.dmi_hard_reset = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_intf = 1'b0;
        wr_enab = 1'b0;
        dmi.dmi_req_ready  = 1'b0;
        dmi.dmi_rsp_valid  = 1'b0;
        dmi.dmi_rsp_data   = '0;
        dmi.dmi_rsp_err    = 1'b0;
        dmi.dmi_hard_reset = 1'b0;

        // Reset state
        repeat (2) step();
        check_val("rst_valid",  32'(dmi.dmi_req_valid), 32'd0);
        check_val("rst_rddata", rd_data, 32'd0);
        check_val("rst_status", 32'(rd_status), 32'd0);
        rst_n = 1'b1;
        step();
        $display("txn reset done");

        // Read 0x11, ready immediate, response on 3rd RSP cycle
        dmi.dmi_req_ready = 1'b1;
        issue(32'h0000_0011, 32'h0, 1'b0);
        check_val("rd_valid",  32'(dmi.dmi_req_valid), 32'd1);
        check_val("rd_addr",   32'(dmi.dmi_req_addr), 32'h11);
        check_val("rd_write",  32'(dmi.dmi_req_write), 32'd0);
        check_val("rd_busy",   32'(rd_status), 32'h3);
        step();
        check_val("rd_vdrop",  32'(dmi.dmi_req_valid), 32'd0);
        step();
        step();
        respond(32'hDEAD_BEEF, 1'b0);
        check_val("rd_data",   rd_data, 32'hDEAD_BEEF);
        check_val("rd_status", 32'(rd_status), 32'h0);
        $display("txn read 0x11 -> rd_data=0x%08h status=%0b", rd_data, rd_status);

        // Write 0x10, ready low for 5 valid cycles
        dmi.dmi_req_ready = 1'b0;
        issue(32'h0000_0010, 32'h8000_0001, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("wr_valid%0d", i), 32'(dmi.dmi_req_valid), 32'd1);
            check_val($sformatf("wr_addr%0d", i),  32'(dmi.dmi_req_addr), 32'h10);
            check_val($sformatf("wr_data%0d", i),  dmi.dmi_req_data, 32'h8000_0001);
            check_val($sformatf("wr_wr%0d", i),    32'(dmi.dmi_req_write), 32'd1);
            if (i == 5) dmi.dmi_req_ready = 1'b1;
            step();
        end
        check_val("wr_vdrop", 32'(dmi.dmi_req_valid), 32'd0);
        dmi.dmi_req_ready = 1'b0;
        respond(32'h1234_5678, 1'b0);
        check_val("wr_rddata", rd_data, 32'hDEAD_BEEF);
        check_val("wr_status", 32'(rd_status), 32'h0);
        $display("txn write 0x10 data=0x80000001 status=%0b", rd_status);

        // Response outside RSP is ignored
        respond(32'h5555_AAAA, 1'b0);
        check_val("idle_rsp", rd_data, 32'hDEAD_BEEF);
        $display("txn stray response ignored");

        // Second strobe during RSP -> sticky busy
        dmi.dmi_req_ready = 1'b1;
        issue(32'h0000_0022, 32'h0, 1'b0);
        step();
        issue(32'h0000_0033, 32'h0, 1'b0);
        check_val("bz_status", 32'(rd_status), 32'h3);
        respond(32'hCAFE_F00D, 1'b0);
        check_val("bz_after", 32'(rd_status), 32'h3);
        check_val("bz_rddata", rd_data, 32'hCAFE_F00D);
        issue(32'h0000_0044, 32'h0, 1'b0);
        check_val("bz_drop", 32'(dmi.dmi_req_valid), 32'd0);
        hard_reset();
        check_val("hr_status", 32'(rd_status), 32'h0);
        issue(32'h0000_0005, 32'h0, 1'b0);
        check_val("hr_valid", 32'(dmi.dmi_req_valid), 32'd1);
        check_val("hr_addr",  32'(dmi.dmi_req_addr), 32'h05);
        step();
        respond(32'h0000_0055, 1'b0);
        check_val("hr_rddata", rd_data, 32'h0000_0055);
        $display("txn busy/hard-reset sequence status=%0b", rd_status);

        // Timeout after 8 RSP cycles
        issue(32'h0000_0006, 32'h0, 1'b0);
        step();
        repeat (7) step();
        check_val("to_pre", 32'(rd_status), 32'h3);
        step();
        check_val("to_status", 32'(rd_status), 32'h2);
        hard_reset();
        $display("txn response timeout");

        // Response on the 8th RSP cycle beats expiry
        issue(32'h0000_0007, 32'h0, 1'b0);
        step();
        repeat (7) step();
        respond(32'hA5A5_A5A5, 1'b0);
        check_val("tc_status", 32'(rd_status), 32'h0);
        check_val("tc_rddata", rd_data, 32'hA5A5_A5A5);
        $display("txn response coincident with expiry");

        // Error response on a read
        issue(32'h0000_0008, 32'h0, 1'b0);
        step();
        respond(32'h1111_1111, 1'b1);
        check_val("er_status", 32'(rd_status), 32'h2);
        check_val("er_rddata", rd_data, 32'hA5A5_A5A5);
        hard_reset();
        $display("txn error response");

        // Reset asserted mid-REQ
        dmi.dmi_req_ready = 1'b0;
        issue(32'h0000_007F, 32'hFFFF_0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_valid",  32'(dmi.dmi_req_valid), 32'd0);
        check_val("ar_addr",   32'(dmi.dmi_req_addr), 32'd0);
        check_val("ar_data",   dmi.dmi_req_data, 32'd0);
        check_val("ar_write",  32'(dmi.dmi_req_write), 32'd0);
        check_val("ar_rddata", rd_data, 32'd0);
        check_val("ar_status", 32'(rd_status), 32'd0);
        step();
        rst_n = 1'b1;
        respond(32'h9999_9999, 1'b0);
        check_val("ar_norsp", rd_data, 32'd0);
        $display("txn reset mid-REQ");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dmi_req_ctrl.md
DMI_REQ_CTRL -- requirements
Module: dmi_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7: DMI address width taken from wr_addr[ADDR_W-1:0].
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles spent in REQ or RSP before the access fails.
REQ-003 jtag_tck  in  1  sole clock; all logic rising-edge.
REQ-004 jtag_trst_n  in  1  reset, asynchronous, active-low.
REQ-005 wr_addr  in  32  DMI address from the DR; low ADDR_W bits used.
REQ-006 wr_data  in  32  DMI write data from the DR.
REQ-007 wr_intf  in  1  one-cycle request strobe (DR update).
REQ-008 wr_enab  in  1  qualifies wr_intf: 1 = write, 0 = read.
REQ-009 rd_data  out  32  last read response data, captured into the DR.
REQ-010 rd_status  out  2  00 ok, 10 failed, 11 busy.
REQ-011 dmi_req_valid  out  1; dmi_req_ready  in  1; dmi_req_addr  out  ADDR_W; dmi_req_data  out  32; dmi_req_write  out  1: request channel to the debug module.
REQ-012 dmi_rsp_valid  in  1; dmi_rsp_data  in  32; dmi_rsp_err  in  1: one-cycle response from the debug module.
REQ-013 dmi_hard_reset  in  1  one-cycle pulse that clears sticky status and aborts any outstanding access.

Function
REQ-014 SHALL implement the FSM states IDLE, REQ and RSP.
REQ-015 IDLE: wr_intf=1 with sticky=00 SHALL latch addr, data and write, then enter REQ; dmi_req_valid goes high on the next cycle.
REQ-016 REQ: dmi_req_valid and its payload SHALL hold stable until dmi_req_ready=1; valid&ready SHALL enter RSP on the next cycle, and valid drops then.
REQ-017 RSP: dmi_rsp_valid=1 SHALL return to IDLE on the next cycle; dmi_rsp_err=1 SHALL set sticky=10.
REQ-018 A read response without error SHALL load rd_data from dmi_rsp_data; writes and errored responses SHALL leave rd_data unchanged.
REQ-019 dmi_rsp_valid outside RSP SHALL be ignored.
REQ-020 The timeout counter SHALL clear on entry to REQ and to RSP, and SHALL increment each cycle in those states. At TIMEOUT_CYCLES-1 with no handshake or response, it SHALL set sticky=10, drop valid and enter IDLE.
REQ-021 When response and timeout expiry coincide, the response SHALL win.
REQ-022 wr_intf=1 while not IDLE SHALL be dropped and SHALL set sticky=11 unless sticky is already nonzero; the in-flight access SHALL continue.
REQ-023 wr_intf=1 in IDLE with sticky≠00 SHALL be dropped without issuing a request.
REQ-024 rd_status SHALL equal sticky when sticky≠00; otherwise 11 when the state is not IDLE; otherwise 00.
REQ-025 Once set, sticky SHALL hold until dmi_hard_reset or reset; the first error wins.
REQ-026 dmi_hard_reset SHALL clear sticky, force IDLE and drop dmi_req_valid on the next cycle; it SHALL take priority over a same-cycle wr_intf or response.
REQ-027 wr_intf=1 with wr_enab=0 and with wr_enab=1 SHALL both issue requests; no other no-op decode is performed.

Reset
REQ-028 Asserting jtag_trst_n low SHALL immediately force state IDLE, sticky=00, rd_data=0, rd_status=00, dmi_req_valid=0, dmi_req_addr/data/write=0 and timeout counter=0.
REQ-029 Reset mid-access SHALL abandon the access; no response SHALL be consumed afterwards.

Structure
REQ-030 A shared package SHALL hold the status encodings (DMI_OK=2'b00, DMI_FAIL=2'b10, DMI_BUSY=2'b11) and the FSM state enum.
REQ-031 The timeout counter SHALL be a sub-module dmi_timeout_cnt (clear, enable, expire output) with width $clog2(TIMEOUT_CYCLES).
REQ-032 The block SHALL be single-clock with no internal clock-domain crossings.

Verification
REQ-033 Read, addr 0x11, ready immediate, response 0xDEADBEEF on the 3rd RSP cycle -> request visible 1 cycle after wr_intf; rd_data=0xDEADBEEF and rd_status=00 1 cycle after the response.
REQ-034 Write, addr 0x10, data 0x80000001, ready held low 5 cycles -> valid and payload stable for 6 cycles; rd_data unchanged; status returns to 00.
REQ-035 Second wr_intf during RSP -> rd_status=11 stays after completion; next wr_intf issues no request; dmi_hard_reset -> 00 and the following request is accepted.
REQ-036 With TIMEOUT_CYCLES=8 and no response -> IDLE and rd_status=10 after exactly 8 RSP cycles; response on cycle 8 coincident with expiry -> status 00.
REQ-037 dmi_rsp_err=1 on a read -> rd_status=10 and rd_data retains its prior value; jtag_trst_n low mid-REQ -> all outputs zero immediately.
